// File: rtl/pipe_stall_sched_pkg.sv
// ============================================================================
// Module   : pipe_stall_sched_pkg
// Brief    : Shared constants and state encoding for the stall/flush sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_stall_sched_pkg;

  localparam int   WORD_WIDTH = 32;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  typedef enum logic [0:0] {
    PSS_RUN        = 1'b0,
    PSS_REDIR_WAIT = 1'b1
  } pss_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_sched_if.sv
// ============================================================================
// Module   : pipe_stall_sched_if
// Brief    : Hazard inputs and per-stage control outputs of the sequencer.
//            Perf counter signals exist only with PIPE_STALL_PERF_EN defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_stall_sched_if
  import pipe_stall_sched_pkg::*;
#(
  parameter int W = WORD_WIDTH
);

  logic         mem_ex_hazard;
  logic         j_ctrl_hazard;
  logic         branch_ctrl_hazard;
  logic [W-1:0] flush_addr;
  logic         if_busy;
  logic         mem_busy;
  logic         mdu_busy;

  logic         pc_stall;
  logic         if_id_stall;
  logic         if_id_bubble;
  logic         id_ex_stall;
  logic         id_ex_bubble;
  logic         ex_mem_stall;
  logic         ex_mem_bubble;
  logic         mem_wb_bubble;
  logic         redirect_valid;
  logic [W-1:0] redirect_addr;
  logic         if_kill;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0]  perf_stall_cycles;
  logic [31:0]  perf_flush_count;
  logic [31:0]  perf_redirect_wait_cycles;
`endif

  // master: hazard detectors / pipeline side; slave: the sequencer
  modport master (
    output mem_ex_hazard, j_ctrl_hazard, branch_ctrl_hazard, flush_addr,
    output if_busy, mem_busy, mdu_busy,
    input  pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble,
    input  ex_mem_stall, ex_mem_bubble, mem_wb_bubble,
    input  redirect_valid, redirect_addr, if_kill
`ifdef PIPE_STALL_PERF_EN
    ,
    input  perf_stall_cycles, perf_flush_count, perf_redirect_wait_cycles
`endif
  );

  modport slave (
    input  mem_ex_hazard, j_ctrl_hazard, branch_ctrl_hazard, flush_addr,
    input  if_busy, mem_busy, mdu_busy,
    output pc_stall, if_id_stall, if_id_bubble, id_ex_stall, id_ex_bubble,
    output ex_mem_stall, ex_mem_bubble, mem_wb_bubble,
    output redirect_valid, redirect_addr, if_kill
`ifdef PIPE_STALL_PERF_EN
    ,
    output perf_stall_cycles, perf_flush_count, perf_redirect_wait_cycles
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stall_sched_prio.sv
// ============================================================================
// Module   : pipe_stall_prio
// Brief    : Combinational priority resolver: hazards -> stage controls and
//            redirect request/issue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stall_prio
  import pipe_stall_sched_pkg::*;
(
  input  logic i_mem_busy,
  input  logic i_branch,
  input  logic i_mdu_busy,
  input  logic i_jump,
  input  logic i_load_use,
  input  logic i_if_busy,
  input  logic i_in_wait,
  output logic o_pc_stall,
  output logic o_if_id_stall,
  output logic o_if_id_bubble,
  output logic o_id_ex_stall,
  output logic o_id_ex_bubble,
  output logic o_ex_mem_stall,
  output logic o_ex_mem_bubble,
  output logic o_mem_wb_bubble,
  output logic o_redir_req,
  output logic o_redir_issue
);

  logic w_pc_hold;
  logic w_if_id_bub_raw;

  always_comb begin
    w_pc_hold       = FALSE;
    w_if_id_bub_raw = FALSE;
    o_if_id_stall   = FALSE;
    o_id_ex_stall   = FALSE;
    o_id_ex_bubble  = FALSE;
    o_ex_mem_stall  = FALSE;
    o_ex_mem_bubble = FALSE;
    o_mem_wb_bubble = FALSE;
    o_redir_req     = FALSE;
    o_redir_issue   = FALSE;
    o_pc_stall      = FALSE;
    o_if_id_bubble  = FALSE;

    if (i_mem_busy) begin
      w_pc_hold       = TRUE;
      o_if_id_stall   = TRUE;
      o_id_ex_stall   = TRUE;
      o_ex_mem_stall  = TRUE;
      o_mem_wb_bubble = TRUE;
    end else if (i_branch) begin
      w_if_id_bub_raw = TRUE;
      o_id_ex_bubble  = TRUE;
      o_redir_req     = TRUE;
    end else if (i_mdu_busy) begin
      w_pc_hold       = TRUE;
      o_if_id_stall   = TRUE;
      o_id_ex_stall   = TRUE;
      o_ex_mem_bubble = TRUE;
    end else if (i_jump && !i_in_wait) begin
      // a jump seen while a redirect is pending is on the wrong path
      w_if_id_bub_raw = TRUE;
      o_redir_req     = TRUE;
    end else if (i_load_use) begin
      w_pc_hold       = TRUE;
      o_if_id_stall   = TRUE;
      o_id_ex_bubble  = TRUE;
    end

    o_redir_issue  = !i_mem_busy && !i_if_busy && (o_redir_req || i_in_wait);
    // the PC must be free to load the target on the issue cycle
    o_pc_stall     = (w_pc_hold || i_if_busy || i_in_wait) && !o_redir_issue;
    o_if_id_bubble = (w_if_id_bub_raw || i_if_busy || i_in_wait) && !o_if_id_stall;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stall_sched.sv
// ============================================================================
// Module   : pipe_stall_sched
// Brief    : Pipeline stall/flush sequencer with pending PC redirect.
//            Optional perf counters enabled by PIPE_STALL_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stall_sched
  import pipe_stall_sched_pkg::*;
#(
  parameter int W = WORD_WIDTH
)(
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_stall_sched_if.slave    bus
);

  pss_state_e   r_state;
  pss_state_e   w_state_nxt;
  logic [W-1:0] r_pend_addr;
  logic [W-1:0] w_pend_nxt;
  logic         w_if_kill;

  logic w_pc_stall, w_if_id_stall, w_if_id_bubble, w_id_ex_stall, w_id_ex_bubble;
  logic w_ex_mem_stall, w_ex_mem_bubble, w_mem_wb_bubble;
  logic w_redir_req, w_redir_issue;

  pipe_stall_prio u_prio (
    .i_mem_busy      (bus.mem_busy),
    .i_branch        (bus.branch_ctrl_hazard),
    .i_mdu_busy      (bus.mdu_busy),
    .i_jump          (bus.j_ctrl_hazard),
    .i_load_use      (bus.mem_ex_hazard),
    .i_if_busy       (bus.if_busy),
    .i_in_wait       (r_state == PSS_REDIR_WAIT),
    .o_pc_stall      (w_pc_stall),
    .o_if_id_stall   (w_if_id_stall),
    .o_if_id_bubble  (w_if_id_bubble),
    .o_id_ex_stall   (w_id_ex_stall),
    .o_id_ex_bubble  (w_id_ex_bubble),
    .o_ex_mem_stall  (w_ex_mem_stall),
    .o_ex_mem_bubble (w_ex_mem_bubble),
    .o_mem_wb_bubble (w_mem_wb_bubble),
    .o_redir_req     (w_redir_req),
    .o_redir_issue   (w_redir_issue)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= PSS_RUN;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_addr <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_addr;
    w_if_kill   = FALSE;
    case (r_state)
      PSS_RUN: begin
        if (w_redir_req && bus.if_busy) begin
          w_pend_nxt  = bus.flush_addr;
          w_state_nxt = PSS_REDIR_WAIT;
          w_if_kill   = TRUE;
        end
      end
      PSS_REDIR_WAIT: begin
        if (w_redir_issue) begin
          w_state_nxt = PSS_RUN;
        end else if (w_redir_req) begin
          // a younger branch replaces the pending target
          w_pend_nxt = bus.flush_addr;
        end
      end
      default: w_state_nxt = PSS_RUN;
    endcase
  end

  // outputs are forced quiet while reset is held, independent of inputs
  assign bus.pc_stall       = rst_n && w_pc_stall;
  assign bus.if_id_stall    = rst_n && w_if_id_stall;
  assign bus.if_id_bubble   = rst_n && w_if_id_bubble;
  assign bus.id_ex_stall    = rst_n && w_id_ex_stall;
  assign bus.id_ex_bubble   = rst_n && w_id_ex_bubble;
  assign bus.ex_mem_stall   = rst_n && w_ex_mem_stall;
  assign bus.ex_mem_bubble  = rst_n && w_ex_mem_bubble;
  assign bus.mem_wb_bubble  = rst_n && w_mem_wb_bubble;
  assign bus.redirect_valid = rst_n && w_redir_issue;
  assign bus.if_kill        = rst_n && w_if_kill;
  assign bus.redirect_addr  = (rst_n && w_redir_issue)
                            ? (w_redir_req ? bus.flush_addr : r_pend_addr)
                            : '0;

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_wait  <= '0;
    end else begin
      if (w_pc_stall)                 r_perf_stall <= r_perf_stall + 32'd1;
      if (w_redir_issue)              r_perf_flush <= r_perf_flush + 32'd1;
      if (r_state == PSS_REDIR_WAIT)  r_perf_wait  <= r_perf_wait + 32'd1;
    end
  end

  assign bus.perf_stall_cycles         = r_perf_stall;
  assign bus.perf_flush_count          = r_perf_flush;
  assign bus.perf_redirect_wait_cycles = r_perf_wait;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_sched.sv
// ============================================================================
// Module   : tb_pipe_stall_sched
// Brief    : Scoreboard bench for pipe_stall_sched; one task per scenario.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stall_sched;

  // input bit order {load_use, jump, branch, if_busy, mem_busy, mdu_busy}
  localparam logic [5:0] LU = 6'h20, J = 6'h10, BR = 6'h08, IFB = 6'h04, MEMB = 6'h02, MDU = 6'h01;
  localparam logic [5:0] NONE = 6'h00;
  // control bit order {pc_s, ifid_s, ifid_b, idex_s, idex_b, exm_s, exm_b, mwb_b, rv, kill}
  localparam logic [9:0] PC_S = 10'h200, IFID_S = 10'h100, IFID_B = 10'h080, IDEX_S = 10'h040;
  localparam logic [9:0] IDEX_B = 10'h020, EXM_S = 10'h010, EXM_B = 10'h008, MWB_B = 10'h004;
  localparam logic [9:0] RV = 10'h002, KILL = 10'h001, QUIET = 10'h000;

  typedef struct packed {
    logic        rst_n;
    logic [5:0]  in;
    logic [31:0] fa;
    logic [9:0]  ctl;
    logic [31:0] addr;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [41:0] sb[$];

  always #5 clk = ~clk;

  pipe_stall_sched_if #(.W(32)) bus ();

  pipe_stall_sched #(.W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic row_t mk(input logic r, input logic [5:0] in, input logic [31:0] fa,
                              input logic [9:0] ctl, input logic [31:0] addr);
    row_t t;
    t.rst_n = r; t.in = in; t.fa = fa; t.ctl = ctl; t.addr = addr;
    return t;
  endfunction

  function automatic logic [41:0] sample();
    return {bus.pc_stall, bus.if_id_stall, bus.if_id_bubble, bus.id_ex_stall, bus.id_ex_bubble,
            bus.ex_mem_stall, bus.ex_mem_bubble, bus.mem_wb_bubble, bus.redirect_valid,
            bus.if_kill, bus.redirect_addr};
  endfunction

  // drive one cycle of stimulus on the falling edge and queue its expectation
  task automatic apply(input row_t r);
    @(negedge clk);
    rst_n = r.rst_n;
    {bus.mem_ex_hazard, bus.j_ctrl_hazard, bus.branch_ctrl_hazard,
     bus.if_busy, bus.mem_busy, bus.mdu_busy} = r.in;
    bus.flush_addr = r.fa;
    sb.push_back({r.ctl, r.addr});
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b0, MEMB | BR | LU | IFB, 32'h0000_1234, QUIET, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, LU, 32'h0, PC_S | IFID_S | IDEX_B, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL load_use[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_branch_jump_ready();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, BR, 32'h0040_0020, IFID_B | IDEX_B | RV, 32'h0040_0020));
    rows.push_back(mk(1'b1, NONE, 32'h0040_0020, QUIET, 32'h0));
    rows.push_back(mk(1'b1, J, 32'h0040_0080, IFID_B | RV, 32'h0040_0080));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL branch_jump[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_if_busy();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, IFB, 32'h0, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b1, IFB | LU, 32'h0, PC_S | IFID_S | IDEX_B, 32'h0));
    rows.push_back(mk(1'b1, IFB | MDU, 32'h0, PC_S | IFID_S | IDEX_S | EXM_B, 32'h0));
    rows.push_back(mk(1'b1, MDU | J, 32'h0040_0700, PC_S | IFID_S | IDEX_S | EXM_B, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL if_busy[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_jump_busy();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, J | IFB, 32'h0040_0100, PC_S | IFID_B | KILL, 32'h0));
    rows.push_back(mk(1'b1, IFB, 32'h0, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b1, IFB, 32'h0, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, RV | IFID_B, 32'h0040_0100));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL jump_busy[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_wait_overwrite();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, J | IFB, 32'h0000_0100, PC_S | IFID_B | KILL, 32'h0));
    rows.push_back(mk(1'b1, BR | IFB, 32'h0000_0200, PC_S | IFID_B | IDEX_B, 32'h0));
    rows.push_back(mk(1'b1, J | IFB, 32'h0000_0300, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, RV | IFID_B, 32'h0000_0200));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL wait_overwrite[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_mem_busy();
    row_t rows[$];
    logic [41:0] got, want;
    logic [9:0] all_stall;
    all_stall = PC_S | IFID_S | IDEX_S | EXM_S | MWB_B;
    rows.push_back(mk(1'b1, MEMB | BR | MDU, 32'h0040_0400, all_stall, 32'h0));
    rows.push_back(mk(1'b1, MEMB | BR | MDU, 32'h0040_0400, all_stall, 32'h0));
    rows.push_back(mk(1'b1, BR | MDU, 32'h0040_0400, IFID_B | IDEX_B | RV, 32'h0040_0400));
    rows.push_back(mk(1'b1, MDU, 32'h0, PC_S | IFID_S | IDEX_S | EXM_B, 32'h0));
    // mem_busy while a redirect is pending keeps it pending even with fetch free
    rows.push_back(mk(1'b1, J | IFB, 32'h0040_0600, PC_S | IFID_B | KILL, 32'h0));
    rows.push_back(mk(1'b1, MEMB, 32'h0, all_stall, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, RV | IFID_B, 32'h0040_0600));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL mem_busy[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    row_t rows[$];
    logic [41:0] got, want;
    rows.push_back(mk(1'b1, J | IFB, 32'h0040_0500, PC_S | IFID_B | KILL, 32'h0));
    rows.push_back(mk(1'b1, IFB, 32'h0, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b0, IFB, 32'h0, QUIET, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    rows.push_back(mk(1'b1, IFB, 32'h0, PC_S | IFID_B, 32'h0));
    rows.push_back(mk(1'b1, NONE, 32'h0, QUIET, 32'h0));
    foreach (rows[i]) begin
      apply(rows[i]);
      got = sample(); want = sb.pop_front(); n_vec++;
      if (got !== want) begin
        n_miss++; $display("FAIL reset_mid_wait[%0d] got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    {bus.mem_ex_hazard, bus.j_ctrl_hazard, bus.branch_ctrl_hazard,
     bus.if_busy, bus.mem_busy, bus.mdu_busy} = NONE;
    bus.flush_addr = 32'h0;
    test_reset();
    test_load_use();
    test_branch_jump_ready();
    test_if_busy();
    test_jump_busy();
    test_wait_overwrite();
    test_mem_busy();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
